axi_wr_master: RTL and testbench

- Downstream neighbour of the OFM flattening stage.
- Consumes its write request (wmst_req, wmst_addr, wmst_xfer_size) and its 512-bit output stream (tdata/valid/ready).
- Turns each request into AXI4 INCR write bursts to device memory, then returns a one-cycle wmst_done.
- One request is processed at a time; the write channels carry one burst at a time.

---
 rtl/acc_pkg.sv | 18 +
 rtl/axi_wr_master_burst_calc.sv | 23 ++
 rtl/axi_wr_master.sv | 149 ++++++++++++++
 tb/tb_axi_wr_master.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared AXI constants and write-master state encoding for the accelerator datapath.
package acc_pkg;

  localparam int          WORD_BYTE      = 64;
  localparam logic [2:0]  AXI_SIZE_64B   = 3'd6;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } wr_state_e;

endpackage

// File: rtl/axi_wr_master_burst_calc.sv
// Burst sizing: min(beats remaining, MAX_BURST, beats left before the next 4 KB boundary).
module burst_calc #(
  parameter int MAX_BURST = 16
) (
  input  logic [31:0] beats_left_i,
  input  logic [5:0]  blk_i,
  output logic [8:0]  burst_beats_o
);

  logic [8:0] beats_sat;
  logic [8:0] to_4k;
  logic [8:0] lim;

  always_comb begin
    // Anything above 256 beats is clamped to the largest possible AXI burst first.
    beats_sat = (|beats_left_i[31:8]) ? 9'd256 : {1'b0, beats_left_i[7:0]};
    to_4k     = 9'd64 - {3'd0, blk_i};
    lim       = (beats_sat < 9'(MAX_BURST)) ? beats_sat : 9'(MAX_BURST);
    if (to_4k < lim) lim = to_4k;
    burst_beats_o = lim;
  end

endmodule

// File: rtl/axi_wr_master.sv
// Converts a (address, size) write request plus a 512-bit stream into AXI4 INCR bursts.
module axi_wr_master
  import acc_pkg::*;
#(
  parameter int DATA_W    = 512,
  parameter int ADDR_W    = 64,
  parameter int MAX_BURST = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wmst_req,
  input  logic [ADDR_W-1:0]   wmst_addr,
  input  logic [63:0]         wmst_xfer_size,
  output logic                wmst_done,
  output logic                wmst_err,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  input  logic [1:0]          m_axi_bresp
);

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [31:0]       beats_left_q, beats_left_d;
  logic [8:0]        burst_q, burst_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [7:0]        awlen_q, awlen_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic              err_q, err_d;
  logic [8:0]        calc_beats;
  logic [31:0]       req_beats;
  logic              wlast_w;

  burst_calc #(.MAX_BURST(MAX_BURST)) u_burst_calc (
    .beats_left_i  (beats_left_q),
    .blk_i         (cur_addr_q[11:6]),
    .burst_beats_o (calc_beats)
  );

  // Oversized requests saturate rather than silently wrapping the beat count.
  assign req_beats = (|wmst_xfer_size[63:38]) ? 32'hFFFF_FFFF
                   : wmst_xfer_size[37:6] + {31'd0, |wmst_xfer_size[5:0]};

  assign wlast_w = (state_q == ST_W) && (beat_cnt_q == awlen_q);

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    burst_d      = burst_q;
    awaddr_d     = awaddr_q;
    awlen_d      = awlen_q;
    beat_cnt_d   = beat_cnt_q;
    err_d        = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wmst_req) begin
          cur_addr_d   = {wmst_addr[ADDR_W-1:6], 6'b0};
          beats_left_d = req_beats;
          err_d        = |wmst_addr[5:0];
          state_d      = ST_CALC;
        end
      end
      ST_CALC: begin
        if (beats_left_q == 32'd0) begin
          state_d = ST_DONE;
        end else begin
          burst_d  = calc_beats;
          awaddr_d = cur_addr_q;
          awlen_d  = calc_beats[7:0] - 8'd1;
          state_d  = ST_AW;
        end
      end
      ST_AW: begin
        if (m_axi_awready) begin
          beat_cnt_d = '0;
          state_d    = ST_W;
        end
      end
      ST_W: begin
        if (s_tvalid && m_axi_wready) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (wlast_w) state_d = ST_B;
        end
      end
      ST_B: begin
        if (m_axi_bvalid) begin
          beats_left_d = beats_left_q - 32'(burst_q);
          cur_addr_d   = cur_addr_q + ADDR_W'({burst_q, 6'b0});
          if (m_axi_bresp != AXI_RESP_OKAY) err_d = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      burst_q      <= '0;
      awaddr_q     <= '0;
      awlen_q      <= '0;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      burst_q      <= burst_d;
      awaddr_q     <= awaddr_d;
      awlen_q      <= awlen_d;
      beat_cnt_q   <= beat_cnt_d;
      err_q        <= err_d;
    end
  end

  // Write data is a zero-latency pass-through of the stream while in W.
  assign m_axi_awvalid = (state_q == ST_AW);
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = AXI_SIZE_64B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wvalid  = (state_q == ST_W) && s_tvalid;
  assign s_tready      = (state_q == ST_W) && m_axi_wready;
  assign m_axi_wdata   = s_tdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = wlast_w;
  assign m_axi_bready  = (state_q == ST_B);
  assign wmst_done     = (state_q == ST_DONE);
  assign wmst_err      = err_q;

endmodule

// File: tb/tb_axi_wr_master.sv
// Self-checking bench: vector table of requests, burst/data scoreboards, plus hand-written edge sequences.
module tb_axi_wr_master;

  localparam int MAXB = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wmst_req;
  logic [63:0]  wmst_addr;
  logic [63:0]  wmst_xfer_size;
  logic         wmst_done;
  logic         wmst_err;
  logic [511:0] s_tdata;
  logic         s_tvalid;
  logic         s_tready;
  logic         m_axi_awvalid;
  logic         m_axi_awready;
  logic [63:0]  m_axi_awaddr;
  logic [7:0]   m_axi_awlen;
  logic [2:0]   m_axi_awsize;
  logic [1:0]   m_axi_awburst;
  logic         m_axi_wvalid;
  logic         m_axi_wready;
  logic [511:0] m_axi_wdata;
  logic [63:0]  m_axi_wstrb;
  logic         m_axi_wlast;
  logic         m_axi_bvalid;
  logic         m_axi_bready;
  logic [1:0]   m_axi_bresp;

  always #5 clk = ~clk;

  axi_wr_master #(.DATA_W(512), .ADDR_W(64), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .wmst_req(wmst_req), .wmst_addr(wmst_addr), .wmst_xfer_size(wmst_xfer_size),
    .wmst_done(wmst_done), .wmst_err(wmst_err),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp)
  );

  typedef struct {
    logic [63:0] addr;
    logic [63:0] size;
    int          bad_burst;
    bit          rnd;
    int          exp_nb;
    logic [63:0] exp_last_aw;
    logic [7:0]  exp_last_len;
    bit          exp_err;
  } vec_t;

  vec_t          vecs [8];
  int            total = 0;
  int            bad   = 0;
  logic [71:0]   exp_aw_q [$];
  logic [511:0]  exp_d_q  [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] pat(input int k);
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'(k * 16 + i) ^ 32'h5A5A_0000;
    return v;
  endfunction

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "awvalid"}, 64'(m_axi_awvalid), 0);
    chk({pfx, "wvalid"},  64'(m_axi_wvalid), 0);
    chk({pfx, "wlast"},   64'(m_axi_wlast), 0);
    chk({pfx, "bready"},  64'(m_axi_bready), 0);
    chk({pfx, "s_tready"},64'(s_tready), 0);
    chk({pfx, "done"},    64'(wmst_done), 0);
    chk({pfx, "err"},     64'(wmst_err), 0);
    chk({pfx, "awaddr"},  m_axi_awaddr, 0);
    chk({pfx, "awlen"},   64'(m_axi_awlen), 0);
  endtask

  task automatic run_txn(input vec_t v, input int abort_beats);
    logic [63:0]  a;
    longint       left;
    int           n, exp_beats;
    int           src_idx, beat_in, cur_len, nb_seen, beats_seen, done_cnt, after, burst_idx;
    bit           presented, b_pend, in_w, aw_hold, fin;
    logic [63:0]  hold_addr, last_addr;
    logic [7:0]   hold_len, last_len;
    logic [71:0]  aw_e;
    logic [511:0] d_e;
    exp_aw_q.delete();
    exp_d_q.delete();
    a = {v.addr[63:6], 6'b0};
    left = longint'((v.size + 64'd63) / 64'd64);
    exp_beats = int'(left);
    while (left > 0) begin
      n = 64 - int'(a[11:6]);
      if (n > MAXB) n = MAXB;
      if (longint'(n) > left) n = int'(left);
      exp_aw_q.push_back({a, 8'(n - 1)});
      a = a + 64'(n * 64);
      left = left - longint'(n);
    end
    src_idx = 0; beat_in = 0; cur_len = 0; nb_seen = 0; beats_seen = 0;
    done_cnt = 0; after = 0; burst_idx = 0;
    presented = 0; b_pend = 0; in_w = 0; aw_hold = 0; fin = 0;
    hold_addr = '0; hold_len = '0; last_addr = '0; last_len = '0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge clk);
      // second pulse lands while busy and must be ignored
      wmst_req       = (cyc == 0 || cyc == 3);
      wmst_addr      = v.addr;
      wmst_xfer_size = v.size;
      m_axi_awready  = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      m_axi_wready   = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_tvalid       = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!presented) begin
        exp_d_q.push_back(pat(src_idx));
        presented = 1;
      end
      s_tdata      = pat(src_idx);
      m_axi_bvalid = b_pend && (v.rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      m_axi_bresp  = (burst_idx == v.bad_burst) ? 2'b10 : 2'b00;
      #1;
      chk("wvalid", 64'(m_axi_wvalid), 64'(in_w & s_tvalid));
      chk("s_tready", 64'(s_tready), 64'(in_w & m_axi_wready));
      chk("bready", 64'(m_axi_bready), 64'(b_pend));
      if (aw_hold) begin
        chk("aw_stable_addr", m_axi_awaddr, hold_addr);
        chk("aw_stable_len", 64'(m_axi_awlen), 64'(hold_len));
      end
      aw_hold   = m_axi_awvalid && !m_axi_awready;
      hold_addr = m_axi_awaddr;
      hold_len  = m_axi_awlen;
      if (m_axi_awvalid && m_axi_awready) begin
        nb_seen++;
        if (exp_aw_q.size() == 0) begin
          chk("aw_extra", 1, 0);
        end else begin
          aw_e = exp_aw_q.pop_front();
          chk("awaddr", m_axi_awaddr, aw_e[71:8]);
          chk("awlen", 64'(m_axi_awlen), 64'(aw_e[7:0]));
          cur_len = int'(aw_e[7:0]);
        end
        chk("awsize", 64'(m_axi_awsize), 6);
        chk("awburst", 64'(m_axi_awburst), 1);
        beat_in = 0; in_w = 1;
        last_addr = m_axi_awaddr; last_len = m_axi_awlen;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        if (exp_d_q.size() == 0) begin
          chk("w_extra", 1, 0);
        end else begin
          d_e = exp_d_q.pop_front();
          total++;
          if (m_axi_wdata !== d_e) begin
            bad++;
            $display("FAIL wdata beat %0d: got 0x%0h expected 0x%0h", beats_seen, m_axi_wdata[63:0], d_e[63:0]);
          end
        end
        chk("wlast", 64'(m_axi_wlast), 64'(beat_in == cur_len));
        chk("wstrb", m_axi_wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
        if (beat_in == cur_len) begin
          in_w = 0; b_pend = 1;
        end
        beat_in++; beats_seen++;
      end
      if (s_tvalid && s_tready) begin
        src_idx++; presented = 0;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_pend = 0; burst_idx++;
      end
      if (wmst_done) done_cnt++;
      if (done_cnt > 0) after++;
      if (after >= 4 || (abort_beats >= 0 && beats_seen == abort_beats)) fin = 1;
    end
    chk("finished_in_budget", 64'(fin), 1);
    if (abort_beats >= 0) begin
      chk("abort_beats", 64'(beats_seen), 64'(abort_beats));
      $display("txn addr=0x%0h size=%0d aborted after %0d beats", v.addr, v.size, beats_seen);
      return;
    end
    chk("done_cnt", 64'(done_cnt), 1);
    chk("nbursts", 64'(nb_seen), 64'(v.exp_nb));
    chk("beats", 64'(beats_seen), 64'(exp_beats));
    chk("aw_left", 64'(exp_aw_q.size()), 0);
    chk("err", 64'(wmst_err), 64'(v.exp_err));
    if (v.exp_nb > 0) begin
      chk("last_awaddr", last_addr, v.exp_last_aw);
      chk("last_awlen", 64'(last_len), 64'(v.exp_last_len));
    end
    $display("txn addr=0x%0h size=%0d bursts=%0d beats=%0d err=%0b", v.addr, v.size, nb_seen, beats_seen, wmst_err);
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{64'h1000, 64'd64,      -1, 1'b0, 1, 64'h1000, 8'd0,  1'b0};
    vecs[1] = '{64'h0000, 64'd2560,    -1, 1'b0, 3, 64'h0800, 8'd7,  1'b0};
    vecs[2] = '{64'h0FC0, 64'd192,     -1, 1'b0, 2, 64'h1000, 8'd1,  1'b0};
    vecs[3] = '{64'h2000, 64'd1285,    -1, 1'b1, 2, 64'h2400, 8'd4,  1'b0};
    vecs[4] = '{64'h3000, 64'd2560,     1, 1'b0, 3, 64'h3800, 8'd7,  1'b1};
    vecs[5] = '{64'h4000, 64'd128,     -1, 1'b0, 1, 64'h4000, 8'd1,  1'b0};
    vecs[6] = '{64'h0F80, 64'd1920,    -1, 1'b1, 3, 64'h1400, 8'd11, 1'b0};
    vecs[7] = '{64'h1010, 64'd64,      -1, 1'b0, 1, 64'h1000, 8'd0,  1'b1};

    rst_n = 1'b0; wmst_req = 0; wmst_addr = '0; wmst_xfer_size = '0;
    s_tdata = '0; s_tvalid = 0; m_axi_awready = 0; m_axi_wready = 0;
    m_axi_bvalid = 0; m_axi_bresp = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("rst_");
    chk("rst_awsize", 64'(m_axi_awsize), 6);
    chk("rst_awburst", 64'(m_axi_awburst), 1);
    chk("rst_wstrb", m_axi_wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_txn(vecs[i], -1);

    // zero-size request: done two edges after the req edge, no AW; req during DONE ignored
    @(negedge clk);
    wmst_req = 1; wmst_addr = 64'h5000; wmst_xfer_size = 64'd0;
    s_tvalid = 0; m_axi_bvalid = 0;
    @(negedge clk);
    wmst_req = 0;
    #1;
    chk("z_done_calc", 64'(wmst_done), 0);
    chk("z_err_cleared", 64'(wmst_err), 0);
    @(negedge clk);
    #1;
    chk("z_done_pulse", 64'(wmst_done), 1);
    chk("z_awvalid", 64'(m_axi_awvalid), 0);
    wmst_req = 1; wmst_xfer_size = 64'd64;
    @(negedge clk);
    wmst_req = 0;
    #1;
    chk("z_done_end", 64'(wmst_done), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk("z_no_aw", 64'(m_axi_awvalid), 0);
      chk("z_no_done", 64'(wmst_done), 0);
    end
    $display("txn addr=0x5000 size=0 zero-length sequence");

    // reset in the middle of a burst, then a clean rerun
    rv = '{64'h6000, 64'd512, -1, 1'b0, 1, 64'h6000, 8'd7, 1'b0};
    run_txn(rv, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst_");
    s_tvalid = 0; m_axi_bvalid = 0; wmst_req = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_txn(rv, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
